// File: rtl/multi_timer.sv
// multi_timer: AHB-Lite slave with NUM_CH up-counters sharing one prescaler tick.
// Defining MULTI_TIMER_IRQ_EN implements CTRL.IE and adds the registered IRQ output.
module multi_timer #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRESCALE   = 32768,
    parameter int unsigned DEF_PERIOD = 3
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
`ifdef MULTI_TIMER_IRQ_EN
    output logic        IRQ,
`endif
    output logic        HREADYOUT
);

    localparam int unsigned PW = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        REG_COUNT  = 2'd0,
        REG_FLAG   = 2'd1,
        REG_PERIOD = 2'd2,
        REG_CTRL   = 2'd3
    } reg_e;

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;
    logic              ph_valid_q, ph_valid_d;
    logic              ph_write_q, ph_write_d;
    logic [4:0]        ph_addr_q, ph_addr_d;
    logic [2:0]        ph_ch;
    reg_e              ph_reg;
    logic              wr_en;

    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [CNT_W-1:0]  last_q   [NUM_CH];
    logic [CNT_W-1:0]  last_d   [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  elapsed  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] flag_q, flag_d;
    logic [NUM_CH-1:0] set_cond;
    logic [NUM_CH-1:0] wr_sel;
`ifdef MULTI_TIMER_IRQ_EN
    logic [NUM_CH-1:0] ie_q, ie_d;
    logic              irq_q, irq_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{HSIZE, HTRANS[0], HADDR[31:7], HADDR[1:0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign tick      = (presc_q == PW'(PRESCALE - 1));
    assign ph_ch     = ph_addr_q[4:2];
    assign ph_reg    = reg_e'(ph_addr_q[1:0]);
    assign wr_en     = ph_valid_q && ph_write_q;

    always_comb begin
        ph_valid_d = HSEL && HREADY && HTRANS[1];
        ph_write_d = HWRITE;
        ph_addr_d  = HADDR[6:2];
        presc_d    = tick ? '0 : presc_q + PW'(1);
    end

    // Elapsed distance is taken modulo 2^CNT_W so the compare survives counter wrap.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            elapsed[c]  = count_q[c] - last_q[c];
            set_cond[c] = (period_q[c] != '0) && (elapsed[c] >= period_q[c]);
            wr_sel[c]   = wr_en && (ph_ch == 3'(c));
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            count_d[c]  = count_q[c];
            last_d[c]   = last_q[c];
            period_d[c] = period_q[c];
            en_d[c]     = en_q[c];
            flag_d[c]   = flag_q[c] | set_cond[c];
`ifdef MULTI_TIMER_IRQ_EN
            ie_d[c]     = ie_q[c];
`endif
            if (tick && en_q[c]) begin
                count_d[c] = count_q[c] + CNT_W'(1);
            end
            // Bus writes are applied last so they override tick and flag set.
            if (wr_sel[c]) begin
                case (ph_reg)
                    REG_COUNT:  count_d[c] = HWDATA[CNT_W-1:0];
                    REG_FLAG: begin
                        last_d[c] = count_q[c];
                        flag_d[c] = 1'b0;
                    end
                    REG_PERIOD: period_d[c] = HWDATA[CNT_W-1:0];
                    REG_CTRL: begin
                        en_d[c] = HWDATA[0];
`ifdef MULTI_TIMER_IRQ_EN
                        ie_d[c] = HWDATA[1];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MULTI_TIMER_IRQ_EN
    always_comb begin
        irq_d = |(flag_q & ie_q);
    end

    assign IRQ = irq_q;
`endif

    always_comb begin
        HRDATA = '0;
        if (ph_valid_q && !ph_write_q) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ph_ch == 3'(c)) begin
                    case (ph_reg)
                        REG_COUNT:  HRDATA = 32'(count_q[c]);
                        REG_FLAG:   HRDATA = {31'b0, flag_q[c]};
                        REG_PERIOD: HRDATA = 32'(period_q[c]);
`ifdef MULTI_TIMER_IRQ_EN
                        REG_CTRL:   HRDATA = {30'b0, ie_q[c], en_q[c]};
`else
                        REG_CTRL:   HRDATA = {31'b0, en_q[c]};
`endif
                        default:    HRDATA = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            presc_q    <= '0;
            ph_valid_q <= 1'b0;
            ph_write_q <= 1'b0;
            ph_addr_q  <= '0;
            en_q       <= '1;
            flag_q     <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                count_q[c]  <= '0;
                last_q[c]   <= '0;
                period_q[c] <= CNT_W'(DEF_PERIOD);
            end
`ifdef MULTI_TIMER_IRQ_EN
            ie_q       <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            presc_q    <= presc_d;
            ph_valid_q <= ph_valid_d;
            ph_write_q <= ph_write_d;
            ph_addr_q  <= ph_addr_d;
            en_q       <= en_d;
            flag_q     <= flag_d;
            count_q    <= count_d;
            last_q     <= last_d;
            period_q   <= period_d;
`ifdef MULTI_TIMER_IRQ_EN
            ie_q       <= ie_d;
            irq_q      <= irq_d;
`endif
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Randomised bench for multi_timer against a cycle-level arithmetic reference model.
module tb_multi_timer;

    localparam int unsigned NCH = 4;
    localparam int unsigned PS  = 4;
    localparam int unsigned MOD = 65536;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic        HREADY;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
`ifdef MULTI_TIMER_IRQ_EN
    logic        IRQ;
`endif

    multi_timer #(
        .NUM_CH    (NCH),
        .CNT_W     (16),
        .PRESCALE  (PS),
        .DEF_PERIOD(3)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HSEL     (HSEL),
        .HREADY   (HREADY),
        .HWRITE   (HWRITE),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HSIZE    (HSIZE),
        .HTRANS   (HTRANS),
        .HRDATA   (HRDATA),
`ifdef MULTI_TIMER_IRQ_EN
        .IRQ      (IRQ),
`endif
        .HREADYOUT(HREADYOUT)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state, as seen just after each clock edge.
    int unsigned m_count  [NCH];
    int unsigned m_last   [NCH];
    int unsigned m_period [NCH];
    bit          m_en     [NCH];
    bit          m_ie     [NCH];
    bit          m_flag   [NCH];
    bit          m_irq;
    int unsigned m_presc;
    bit          m_pv;
    bit          m_pw;
    logic [31:0] m_pa;

    function automatic logic [31:0] exp_rdata();
        logic [2:0] ch;
        ch = m_pa[6:4];
        if (!m_pv || m_pw || ch >= NCH) return '0;
        case (m_pa[3:2])
            2'd0:    return 32'(m_count[ch]);
            2'd1:    return {31'b0, m_flag[ch]};
            2'd2:    return 32'(m_period[ch]);
            default: return {30'b0, m_ie[ch], m_en[ch]};
        endcase
    endfunction

    // Advance the model by one clock from the inputs currently driven, then compare outputs.
    task automatic step();
        int unsigned n_count  [NCH];
        int unsigned n_last   [NCH];
        int unsigned n_period [NCH];
        bit          n_en     [NCH];
        bit          n_ie     [NCH];
        bit          n_flag   [NCH];
        bit          n_irq;
        int unsigned n_presc;
        bit          n_pv;
        bit          n_pw;
        logic [31:0] n_pa;
        bit          tick;
        int unsigned wch;
        n_irq = 0;
        if (HRESET) begin
            for (int c = 0; c < NCH; c++) begin
                n_count[c] = 0; n_last[c] = 0; n_period[c] = 3;
                n_en[c] = 1; n_ie[c] = 0; n_flag[c] = 0;
            end
            n_presc = 0; n_pv = 0; n_pw = 0; n_pa = '0;
        end else begin
            tick = (m_presc == PS - 1);
            for (int c = 0; c < NCH; c++) begin
                n_count[c]  = m_count[c];
                n_last[c]   = m_last[c];
                n_period[c] = m_period[c];
                n_en[c]     = m_en[c];
                n_ie[c]     = m_ie[c];
                n_flag[c]   = m_flag[c] ||
                              (m_period[c] != 0 && ((m_count[c] - m_last[c]) % MOD) >= m_period[c]);
                if (tick && m_en[c]) n_count[c] = (m_count[c] + 1) % MOD;
                if (m_flag[c] && m_ie[c]) n_irq = 1;
            end
            if (m_pv && m_pw && m_pa[6:4] < NCH) begin
                wch = m_pa[6:4];
                case (m_pa[3:2])
                    2'd0: n_count[wch] = HWDATA[15:0];
                    2'd1: begin n_last[wch] = m_count[wch]; n_flag[wch] = 0; end
                    2'd2: n_period[wch] = HWDATA[15:0];
                    default: begin
                        n_en[wch] = HWDATA[0];
`ifdef MULTI_TIMER_IRQ_EN
                        n_ie[wch] = HWDATA[1];
`endif
                    end
                endcase
            end
            n_presc = (m_presc + 1) % PS;
            n_pv    = HSEL && HREADY && HTRANS[1];
            n_pw    = HWRITE;
            n_pa    = HADDR;
        end
        @(posedge HCLK);
        #1;
        m_count = n_count; m_last = n_last; m_period = n_period;
        m_en = n_en; m_ie = n_ie; m_flag = n_flag;
        m_irq = n_irq; m_presc = n_presc;
        m_pv = n_pv; m_pw = n_pw; m_pa = n_pa;
        check("hrdata", HRDATA, exp_rdata());
        check("hreadyout", {31'b0, HREADYOUT}, 32'd1);
`ifdef MULTI_TIMER_IRQ_EN
        check("irq", {31'b0, IRQ}, {31'b0, m_irq});
`endif
    endtask

    function automatic logic [31:0] reg_addr(input int unsigned ch, input int unsigned r);
        logic [31:0] junk;
        junk = $urandom & 32'hFFFF_FF80;
        return junk | 32'(ch * 16 + r * 4);
    endfunction

    task automatic set_idle();
        HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = 2'b00;
        HADDR = $urandom; HWDATA = $urandom; HSIZE = 3'($urandom);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            set_idle();
            step();
        end
    endtask

    task automatic do_reset();
        set_idle();
        HRESET = 1'b1;
        step();
        step();
        HRESET = 1'b0;
    endtask

    task automatic bus_write(input int unsigned ch, input int unsigned r, input logic [31:0] data);
        HSEL = 1'b1; HREADY = 1'b1; HWRITE = 1'b1; HTRANS = {1'b1, 1'($urandom)};
        HADDR = reg_addr(ch, r); HWDATA = $urandom;
        step();
        set_idle();
        HWDATA = data;
        step();
        set_idle();
    endtask

    task automatic bus_read(input int unsigned ch, input int unsigned r, output logic [31:0] data);
        HSEL = 1'b1; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = {1'b1, 1'($urandom)};
        HADDR = reg_addr(ch, r); HWDATA = $urandom;
        step();
        data = HRDATA;
        set_idle();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] wd;
        int unsigned ch, r, op;

        m_presc = 0; m_pv = 0; m_pw = 0; m_pa = '0; m_irq = 0;
        for (int c = 0; c < NCH; c++) begin
            m_count[c] = 0; m_last[c] = 0; m_period[c] = 3;
            m_en[c] = 1; m_ie[c] = 0; m_flag[c] = 0;
        end
        set_idle();
        HRESET = 1'b1;
        do_reset();

        // Reset values.
        bus_read(0, 0, d); check("rst_count0", d, 32'd0);
        for (int c = 0; c < NCH; c++) begin
            bus_read(c, 1, d); check("rst_flag", d, 32'd0);
        end
        for (int c = 0; c < NCH; c++) begin
            bus_read(c, 2, d); check("rst_period", d, 32'd3);
            bus_read(c, 3, d); check("rst_ctrl", d, 32'd1);
        end
        for (int c = NCH; c < 8; c++) begin
            bus_read(c, c % 4, d); check("unmapped_rd", d, 32'd0);
        end

        // Flag timing from reset, ACK and re-arm.
        do_reset();
        idle(11);
        bus_read(0, 1, d); check("flag_before", d, 32'd0);
        bus_read(0, 1, d); check("flag_set", d, 32'd1);
        bus_read(0, 0, d); check("count_at_set", d, 32'd3);
        bus_write(0, 1, $urandom);
        bus_read(0, 1, d); check("flag_acked", d, 32'd0);
        idle(6);
        bus_read(0, 1, d); check("flag_rearm_pre", d, 32'd0);
        bus_read(0, 1, d); check("flag_rearm", d, 32'd1);

        // Counter wrap with a wrapped elapsed distance.
        bus_write(2, 0, 32'h0000_FFFE);
        bus_write(2, 2, 32'd3);
        bus_write(2, 1, 32'd0);
        for (int k = 0; k < 24; k++) bus_read(2, k % 2, d);
        bus_read(2, 1, d); check("wrap_flag", d, 32'd1);
        bus_read(2, 0, d); check("wrap_count_small", {31'b0, d < 32'd16}, 32'd1);

        // COUNT write on a tick edge wins; EN=0 freezes the counter.
        for (int k = 0; k < 8 && m_presc != 2; k++) idle(1);
        bus_write(1, 0, 32'h0000_0100);
        bus_read(1, 0, d); check("write_wins", d, 32'h100);
        bus_write(1, 3, 32'd0);
        bus_write(1, 0, 32'h0000_0200);
        idle(20);
        bus_read(1, 0, d); check("frozen_count", d, 32'h200);
        bus_read(1, 3, d); check("ctrl_en0", d, 32'd0);

        // ACK in the same cycle the set condition first holds.
        bus_write(0, 3, 32'd0);
        bus_write(0, 2, 32'd1);
        bus_write(0, 1, 32'd0);
        bus_write(0, 3, 32'd1);
        for (int k = 0; k < 8 && m_presc != 3; k++) idle(1);
        bus_write(0, 1, 32'd0);
        bus_read(0, 1, d); check("ack_beats_set", d, 32'd0);

        // PERIOD=0 never flags.
        bus_write(3, 2, 32'd0);
        bus_write(3, 1, 32'd0);
        idle(100);
        bus_read(3, 1, d); check("period0_flag", d, 32'd0);

`ifdef MULTI_TIMER_IRQ_EN
        do_reset();
        bus_write(3, 3, 32'd3);
        bus_read(3, 3, d); check("ctrl_ie", d, 32'd3);
        idle(20);
        check("irq_on", {31'b0, IRQ}, 32'd1);
        bus_write(3, 1, 32'd0);
        idle(1);
        check("irq_off_ack", {31'b0, IRQ}, 32'd0);
        bus_write(3, 3, 32'd1);
        idle(40);
        check("irq_ie0", {31'b0, IRQ}, 32'd0);
`else
        bus_write(0, 3, 32'd3);
        bus_read(0, 3, d); check("ctrl_no_ie", d, 32'd1);
`endif

        // Randomised traffic, checked every cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            op = $urandom_range(0, 9);
            ch = $urandom_range(0, 7);
            r  = $urandom_range(0, 3);
            case (op)
                0, 1, 2: bus_read(ch, r, d);
                3, 4: begin
                    case (r)
                        0:       wd = ($urandom_range(0, 1) == 1) ? 32'(16'hFFF0 + $urandom_range(0, 15)) : $urandom;
                        2:       wd = 32'($urandom_range(0, 6));
                        3:       wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'(1 | ($urandom & 2));
                        default: wd = $urandom;
                    endcase
                    bus_write(ch, r, wd);
                end
                5: idle($urandom_range(1, 8));
                6: begin
                    HWRITE = 1'b1; HADDR = reg_addr(ch, r); HWDATA = $urandom;
                    case ($urandom_range(0, 2))
                        0:       begin HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b10; end
                        1:       begin HSEL = 1'b1; HREADY = 1'b1; HTRANS = {1'b0, 1'($urandom)}; end
                        default: begin HSEL = 1'b1; HREADY = 1'b0; HTRANS = 2'b11; end
                    endcase
                    step();
                    set_idle();
                    step();
                end
                7: begin
                    HSEL = 1'b1; HREADY = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10;
                    HADDR = reg_addr(ch, r); HWDATA = $urandom;
                    step();
                    HWRITE = 1'b0; HADDR = reg_addr($urandom_range(0, 3), $urandom_range(0, 3));
                    HWDATA = (r == 2) ? 32'($urandom_range(0, 6)) : $urandom;
                    step();
                    set_idle();
                    step();
                end
                8: begin
                    if ($urandom_range(0, 9) == 0) begin
                        HSEL = 1'b1; HREADY = 1'b1; HWRITE = 1'b1; HTRANS = 2'b10;
                        HADDR = reg_addr(ch, 0); HWDATA = $urandom;
                        step();
                        set_idle();
                        HWDATA = $urandom;
                        HRESET = 1'b1;
                        step();
                        HRESET = 1'b0;
                    end else begin
                        idle(1);
                    end
                end
                default: begin
                    bus_read($urandom_range(0, 3), 1, d);
                    bus_read($urandom_range(0, 3), 0, d);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
